// File: rtl/hilo_unit_pkg.sv
// Shared encodings for the HI/LO sequencer: operation codes, FSM states and default width.
package hilo_unit_pkg;

  localparam int unsigned WidthDefault = 32;

  typedef enum logic [1:0] {
    OpMult = 2'b00,
    OpMthi = 2'b01,
    OpMtlo = 2'b10,
    OpNop  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StClr     = 2'b01,
    StWait    = 2'b10,
    StCapture = 2'b11
  } state_e;

endpackage

// File: rtl/hilo_unit.sv
// HI/LO register pair plus the sequencer that drives the external multi-cycle multiplier,
// serves MTHI/MTLO writes and MFHI/MFLO reads, and holds the pipeline during a multiply.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH        = WidthDefault,
  parameter int unsigned MULT_LATENCY = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  output logic             mult_clr,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MULT_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             clr_q, clr_d;
  op_e              op_in;

  assign op_in = op_e'(op);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          unique case (op_in)
            OpMult: begin
              a_d     = rs_val;
              b_d     = rt_val;
              state_d = StClr;
            end
            OpMthi:  hi_d = rs_val;
            OpMtlo:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StClr: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        hi_d    = mult_hi;
        lo_d    = mult_lo;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Status flags are registered from the next state so they line up with state_q.
    busy_d = (state_d != StIdle);
    clr_d  = (state_d == StClr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
    end
  end

  // Requests arriving mid-multiply are held off, not queued.
  assign stall    = busy_q & (start | rd_req);
  assign rd_data  = rd_sel ? lo_q : hi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mult_clr = clr_q;
  assign mult_a   = a_q;
  assign mult_b   = b_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
